// File: rtl/rectifier_adc_sampler.sv
// Acquisition front end for parallel AD7822 ADCs: shared CONVST/CS/RD sequencing,
// EOC collection with timeout, per-channel averaging and gain/shift scaling to display units.
module rectifier_adc_sampler #(
  parameter int unsigned        N_CH          = 2,
  parameter int unsigned        SAMPLE_PERIOD = 500,
  parameter int unsigned        T_CONVST      = 4,
  parameter int unsigned        T_RD          = 3,
  parameter int unsigned        T_TIMEOUT     = 200,
  parameter int unsigned        AVG_LOG2      = 2,
  parameter logic [8*N_CH-1:0]  GAIN          = {8'd11, 8'd10},
  parameter logic [4*N_CH-1:0]  SHIFT         = {4'd5, 4'd4}
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic              i_clear_err,
  input  logic [8*N_CH-1:0] i_adc_data,
  input  logic [N_CH-1:0]   i_adc_eoc_n,
  output logic              o_adc_convst_n,
  output logic              o_adc_cs_n,
  output logic              o_adc_rd_n,
  output logic [8*N_CH-1:0] o_raw,
  output logic [8*N_CH-1:0] o_value,
  output logic              o_valid,
  output logic              o_timeout
);

  localparam int unsigned AW = 8 + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;
  localparam int unsigned PW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST_CNT   = CW'((1 << AVG_LOG2) - 1);
  localparam logic [PW-1:0] PER_LAST   = PW'(SAMPLE_PERIOD - 1);
  localparam logic [15:0]   CONV_LAST  = 16'(T_CONVST - 1);
  localparam logic [15:0]   RD_LAST    = 16'(T_RD - 1);
  localparam logic [15:0]   TO_LAST    = 16'(T_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_WAIT, S_READ, S_PROC} state_t;

  state_t          state, next_state;
  logic [15:0]     phase;
  logic [PW-1:0]   per_cnt;
  logic            tick;
  logic            timeout_hit;
  logic [N_CH-1:0] eoc_flag;
  logic [CW-1:0]   count;
  logic [AW-1:0]   acc     [N_CH];
  logic [AW-1:0]   acc_sum [N_CH];
  logic [7:0]      mean    [N_CH];
  logic [15:0]     prod    [N_CH];
  logic [15:0]     scaled  [N_CH];
  logic [7:0]      value   [N_CH];

  assign tick = i_enable && (per_cnt == PER_LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)       per_cnt <= '0;
    else if (!i_enable)   per_cnt <= '0;
    else if (tick)        per_cnt <= '0;
    else                  per_cnt <= per_cnt + 1'b1;
  end

  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: if (tick) next_state = S_CONV;
      S_CONV: if (phase == CONV_LAST) next_state = S_WAIT;
      S_WAIT: begin
        if (&eoc_flag) next_state = S_READ;
        else if (phase == TO_LAST) begin
          next_state  = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_READ: if (phase == RD_LAST) next_state = S_PROC;
      S_PROC: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Running sum including the sample captured in READ, and the scaled window result.
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      acc_sum[c] = acc[c] + AW'(o_raw[8*c +: 8]);
      mean[c]    = 8'(acc_sum[c] >> AVG_LOG2);
      prod[c]    = 16'(mean[c]) * 16'(GAIN[8*c +: 8]);
      scaled[c]  = prod[c] >> SHIFT[4*c +: 4];
      value[c]   = (scaled[c] > 16'd255) ? 8'hFF : scaled[c][7:0];
    end
  end

  // Strobes are registered from next_state so they align exactly with the state.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= S_IDLE;
      phase          <= '0;
      o_adc_convst_n <= 1'b1;
      o_adc_cs_n     <= 1'b1;
      o_adc_rd_n     <= 1'b1;
    end else begin
      state          <= next_state;
      phase          <= (state != next_state || state == S_IDLE) ? '0 : phase + 16'd1;
      o_adc_convst_n <= (next_state != S_CONV);
      o_adc_cs_n     <= (next_state != S_READ);
      o_adc_rd_n     <= (next_state != S_READ);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)             eoc_flag <= '0;
    else if (state == S_CONV)   eoc_flag <= '0;
    else if (state == S_WAIT)   eoc_flag <= eoc_flag | ~i_adc_eoc_n;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)        o_timeout <= 1'b0;
    else if (timeout_hit)  o_timeout <= 1'b1;
    else if (i_clear_err)  o_timeout <= 1'b0;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_raw   <= '0;
      o_value <= '0;
      o_valid <= 1'b0;
      count   <= '0;
      for (int unsigned c = 0; c < N_CH; c++) acc[c] <= '0;
    end else begin
      o_valid <= 1'b0;
      if (state == S_READ && phase == RD_LAST) o_raw <= i_adc_data;
      if (state == S_PROC) begin
        if (count == LAST_CNT) begin
          count   <= '0;
          o_valid <= 1'b1;
          for (int unsigned c = 0; c < N_CH; c++) begin
            acc[c]           <= '0;
            o_value[8*c +: 8] <= value[c];
          end
        end else begin
          count <= count + 1'b1;
          for (int unsigned c = 0; c < N_CH; c++) acc[c] <= acc_sum[c];
        end
      end else if (state == S_IDLE && !i_enable) begin
        count <= '0;
        for (int unsigned c = 0; c < N_CH; c++) acc[c] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rectifier_adc_sampler.sv
// Directed bench for rectifier_adc_sampler: ADC handshake driven per sample, window
// results scoreboarded against an independent averaging/scaling model.
module tb_rectifier_adc_sampler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, clear_err;
  logic [15:0] adc_data;
  logic [1:0]  eoc_n;
  logic        convst_n, cs_n, rd_n, o_valid, o_timeout;
  logic [15:0] o_raw, o_value;

  logic        s_enable, s_eoc_n;
  logic [7:0]  s_data, s_raw, s_value;
  logic        s_convst_n, s_cs_n, s_rd_n, s_valid, s_timeout;

  rectifier_adc_sampler dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable), .i_clear_err(clear_err),
    .i_adc_data(adc_data), .i_adc_eoc_n(eoc_n),
    .o_adc_convst_n(convst_n), .o_adc_cs_n(cs_n), .o_adc_rd_n(rd_n),
    .o_raw(o_raw), .o_value(o_value), .o_valid(o_valid), .o_timeout(o_timeout)
  );

  rectifier_adc_sampler #(
    .N_CH(1), .SAMPLE_PERIOD(32), .GAIN(8'd255), .SHIFT(4'd0)
  ) sat_dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(s_enable), .i_clear_err(1'b0),
    .i_adc_data(s_data), .i_adc_eoc_n(s_eoc_n),
    .o_adc_convst_n(s_convst_n), .o_adc_cs_n(s_cs_n), .o_adc_rd_n(s_rd_n),
    .o_raw(s_raw), .o_value(s_value), .o_valid(s_valid), .o_timeout(s_timeout)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;
  int          m_acc [2];
  int          m_cnt;
  int unsigned cyc = 0;
  int unsigned prev_fall;
  bit          have_prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] scale(input int acc, input int g, input int s);
    int p;
    p = ((acc / 4) * g) >> s;
    if (p > 255) p = 255;
    return 8'(p);
  endfunction

  task automatic model_clear();
    m_acc[0] = 0; m_acc[1] = 0; m_cnt = 0;
  endtask

  task automatic model_add(input int d0, input int d1);
    m_acc[0] += d0; m_acc[1] += d1; m_cnt++;
    if (m_cnt == 4) begin
      sb.push_back({scale(m_acc[1], 11, 5), scale(m_acc[0], 10, 4)});
      model_clear();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        mon_exp = sb.pop_front();
        chk("o_value", o_value, mon_exp);
      end
    end
  end

  // One conversion: e0/e1 are EOC pulse offsets (cycles after CONVST seen low), -1 = never.
  task automatic do_sample(input logic [7:0] d0, input logic [7:0] d1, input int e0, input int e1,
                           input int len, input bit early, input int drop_k, input int rst_k,
                           input bit chk_gap);
    bit found;
    bit good;
    int conv_lo, cs_lo, rd_lo, cs_first, to_first;
    found = 0;
    good = (e0 >= 0) && (e1 >= 0);
    for (int i = 0; i < 700 && !found; i++) begin
      @(negedge clk);
      if (!convst_n) found = 1;
    end
    chk("convst_seen", found, 1);
    if (!found) return;
    if (chk_gap && have_prev) chk("tick_spacing", cyc - prev_fall, 500);
    prev_fall = cyc; have_prev = 1;
    adc_data = {d1, d0};
    if (good) model_add(d0, d1);
    conv_lo = 0; cs_lo = 0; rd_lo = 0; cs_first = -1; to_first = -1;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      if (!convst_n) conv_lo++;
      if (!rd_n) rd_lo++;
      if (!cs_n) begin
        cs_lo++;
        if (cs_first < 0) cs_first = k;
      end
      if (o_timeout && to_first < 0) to_first = k;
      if (k == rst_k) begin
        chk("cs_low_before_reset", cs_n, 0);
        rst_n = 1'b0;
        #1;
        chk("strobes_at_reset", {convst_n, cs_n, rd_n}, 3'b111);
        chk("value_at_reset", o_value, 0);
        chk("raw_at_reset", o_raw, 0);
        model_clear();
        eoc_n = '1;
        return;
      end
      eoc_n[0] = !((k == e0) || (early && k == 1));
      eoc_n[1] = !((k == e1) || (early && k == 1));
      if (k == drop_k) enable = 1'b0;
    end
    eoc_n = '1;
    chk("convst_low_cycles", conv_lo, 4);
    chk("cs_low_cycles", cs_lo, good ? 3 : 0);
    chk("rd_low_cycles", rd_lo, good ? 3 : 0);
    if (good) begin
      chk("cs_fall_cycle", cs_first, ((e0 > e1) ? e0 : e1) + 2);
      chk("o_raw", o_raw, {d1, d0});
    end else begin
      chk("timeout_cycle", to_first, 4 + 200);
    end
  endtask

  initial begin
    bit found;
    int cnt;
    rst_n = 1'b0; enable = 1'b0; clear_err = 1'b0; s_enable = 1'b0;
    s_eoc_n = 1'b0; s_data = 8'd2; eoc_n = '1; adc_data = '0;
    have_prev = 0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_strobes", {convst_n, cs_n, rd_n}, 3'b111);
    chk("reset_raw", o_raw, 0);
    chk("reset_value", o_value, 0);
    chk("reset_flags", {o_valid, o_timeout}, 2'b00);
    rst_n = 1'b1;

    s_enable = 1'b1;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (s_valid) found = 1;
    end
    chk("sat_valid_seen", found, 1);
    chk("sat_value", s_value, 255);
    s_enable = 1'b0;

    enable = 1'b1;
    repeat (4) do_sample(160, 200, 10, 10, 30, 0, -1, -1, 1);

    do_sample(100, 200, 10, 10, 30, 0, -1, -1, 1);
    do_sample(104, 200, 10, 10, 30, 1, -1, -1, 1);
    do_sample(108, 200, 4, 12, 30, 0, -1, -1, 1);
    do_sample(112, 200, 10, 10, 30, 0, -1, -1, 1);

    do_sample(50, 255, 10, 10, 30, 0, -1, -1, 1);
    do_sample(0, 0, 10, -1, 220, 0, -1, -1, 1);
    do_sample(60, 255, 6, 9, 30, 0, -1, -1, 1);
    do_sample(70, 255, 10, 10, 30, 0, -1, -1, 1);
    do_sample(80, 255, 10, 10, 30, 0, -1, -1, 1);
    chk("timeout_sticky", o_timeout, 1);
    @(negedge clk) clear_err = 1'b1;
    @(negedge clk) clear_err = 1'b0;
    chk("timeout_cleared", o_timeout, 0);

    do_sample(240, 240, 10, 10, 30, 0, -1, -1, 1);
    do_sample(240, 240, 10, 10, 30, 0, 6, -1, 1);
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!convst_n) cnt++;
    end
    chk("no_convst_disabled", cnt, 0);
    model_clear();
    enable = 1'b1;
    do_sample(20, 40, 10, 10, 30, 0, -1, -1, 0);
    repeat (3) do_sample(20, 40, 10, 10, 30, 0, -1, -1, 1);

    do_sample(250, 250, 10, 10, 30, 0, -1, -1, 1);
    do_sample(250, 250, 10, 10, 30, 0, -1, 13, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_sample(30, 90, 10, 10, 30, 0, -1, -1, 0);
    repeat (3) do_sample(30, 90, 10, 10, 30, 0, -1, -1, 1);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
